ascon_round_sequencer: RTL and testbench

Control stage directly upstream of the Ascon `permutation` datapath. It drives that block's `round_i`, `input_select_i` and `ena_reg_state_i` so that one accepted request runs a full p^a (12 rounds) or p^b (6 rounds) permutation. It then signals completion to the downstream consumer with a valid/ready handshake and holds the state register stable until the result is taken.

---
 rtl/ascon_round_sequencer_if.sv | 39 +++
 rtl/ascon_round_sequencer.sv | 116 +++++++++++
 tb/tb_ascon_round_sequencer.sv | 355 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ascon_round_sequencer_if.sv
// Handshake bundle between the round sequencer and its requester/consumer.
// The slave modport is the sequencer's view; master is the surrounding system.
interface ascon_round_sequencer_if #(
    parameter int CNT_W = 16
);
    logic             start_i;
    logic             mode_i;
    logic             ready_o;
    logic [3:0]       round_o;
    logic             input_select_o;
    logic             ena_reg_state_o;
    logic             valid_o;
    logic             ready_i;
    logic [CNT_W-1:0] perm_count_o;

    modport slave (
        input  start_i,
        input  mode_i,
        input  ready_i,
        output ready_o,
        output round_o,
        output input_select_o,
        output ena_reg_state_o,
        output valid_o,
        output perm_count_o
    );

    modport master (
        output start_i,
        output mode_i,
        output ready_i,
        input  ready_o,
        input  round_o,
        input  input_select_o,
        input  ena_reg_state_o,
        input  valid_o,
        input  perm_count_o
    );
endinterface

// File: rtl/ascon_round_sequencer.sv
// Steps the Ascon permutation datapath through p^a or p^b, always ending on
// round 11, then holds the result until the downstream consumer takes it.
module ascon_round_sequencer #(
    parameter int ROUNDS_A = 12,
    parameter int ROUNDS_B = 6,
    parameter int CNT_W    = 16
) (
    input  logic                    clock_i,
    input  logic                    reset_i,
    ascon_round_sequencer_if.slave  seq
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam logic [3:0] LAST_ROUND = 4'd11;
    localparam logic [3:0] FIRST_A    = 4'(12 - ROUNDS_A);
    localparam logic [3:0] FIRST_B    = 4'(12 - ROUNDS_B);

    state_t           state_q, state_d;
    logic [3:0]       rnd_q, rnd_d;
    logic             m_q, m_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [3:0]       first_sel;
    logic             ready_o_c, input_select_c, ena_c, valid_c;
    logic [3:0]       round_c;

    // The round index alone carries the schedule; the latched mode is kept
    // as a debug-visible record of the request being served.
    logic             unused_mode;
    assign unused_mode = m_q;

    assign first_sel = seq.mode_i ? FIRST_B : FIRST_A;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            rnd_q   <= 4'd0;
            m_q     <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rnd_q   <= rnd_d;
            m_q     <= m_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        rnd_d          = rnd_q;
        m_d            = m_q;
        cnt_d          = cnt_q;
        ready_o_c      = 1'b0;
        input_select_c = 1'b0;
        ena_c          = 1'b0;
        valid_c        = 1'b0;
        round_c        = rnd_q;

        case (state_q)
            S_IDLE: begin
                ready_o_c      = 1'b1;
                input_select_c = 1'b1;
                round_c        = first_sel;
                ena_c          = seq.start_i;
                if (seq.start_i) begin
                    m_d = seq.mode_i;
                    // The first round is registered in this cycle already.
                    if (first_sel == LAST_ROUND) begin
                        state_d = S_DONE;
                    end else begin
                        rnd_d   = first_sel + 4'd1;
                        state_d = S_RUN;
                    end
                end
            end
            S_RUN: begin
                ena_c   = 1'b1;
                round_c = rnd_q;
                if (rnd_q == LAST_ROUND) begin
                    state_d = S_DONE;
                end else begin
                    rnd_d = rnd_q + 4'd1;
                end
            end
            S_DONE: begin
                valid_c = 1'b1;
                round_c = LAST_ROUND;
                if (seq.ready_i) begin
                    state_d = S_IDLE;
                    if (cnt_q != {CNT_W{1'b1}}) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // While reset is held, present a quiet idle face to the datapath.
        if (reset_i) begin
            ready_o_c      = 1'b1;
            input_select_c = 1'b1;
            round_c        = first_sel;
            ena_c          = 1'b0;
            valid_c        = 1'b0;
        end
    end

    assign seq.ready_o         = ready_o_c;
    assign seq.input_select_o  = input_select_c;
    assign seq.ena_reg_state_o = ena_c;
    assign seq.valid_o         = valid_c;
    assign seq.round_o         = round_c;
    assign seq.perm_count_o    = cnt_q;
endmodule

// File: tb/tb_ascon_round_sequencer.sv
// Directed bench for ascon_round_sequencer with a toy stand-in for the
// permutation state register, plus a narrow-counter instance for saturation.
module tb_ascon_round_sequencer;
    logic clk;
    logic rst;
    logic rst_sat;
    int   checks = 0;
    int   errors = 0;

    logic [63:0] ext_in;
    logic [63:0] perm_q;

    ascon_round_sequencer_if #(.CNT_W(16)) bus ();
    ascon_round_sequencer_if #(.CNT_W(2))  bus_sat ();

    ascon_round_sequencer #(.ROUNDS_A(12), .ROUNDS_B(6), .CNT_W(16)) u_dut (
        .clock_i (clk),
        .reset_i (rst),
        .seq     (bus)
    );

    ascon_round_sequencer #(.ROUNDS_A(12), .ROUNDS_B(6), .CNT_W(2)) u_sat (
        .clock_i (clk),
        .reset_i (rst_sat),
        .seq     (bus_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Toy permutation state register: any enabled cycle changes it.
    always @(posedge clk) begin
        if (bus.ena_reg_state_o) begin
            perm_q <= {(bus.input_select_o ? ext_in[62:0] : perm_q[62:0]),
                       (bus.input_select_o ? ext_in[63]   : perm_q[63])}
                      ^ {60'd0, bus.round_o};
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rst_sat = 1'b1;
        bus.start_i = 1'b1;
        bus.mode_i = 1'b0;
        bus.ready_i = 1'b0;
        bus_sat.start_i = 1'b1;
        bus_sat.mode_i = 1'b1;
        bus_sat.ready_i = 1'b1;
        ext_in = 64'h0;
        tick();
        tick();
        #1;
        checks++;
        if ({bus.ready_o, bus.valid_o, bus.ena_reg_state_o, bus.input_select_o} !== 4'b1001) begin
            errors++;
            $display("FAIL reset_flags: got rdy/val/ena/sel=%b expected 1001",
                     {bus.ready_o, bus.valid_o, bus.ena_reg_state_o, bus.input_select_o});
        end
        checks++;
        if (bus.round_o !== 4'd0) begin
            errors++;
            $display("FAIL reset_round_a: got %0d expected 0", bus.round_o);
        end
        checks++;
        if (bus.perm_count_o !== 16'd0) begin
            errors++;
            $display("FAIL reset_count: got %0d expected 0", bus.perm_count_o);
        end
        bus.mode_i = 1'b1;
        #1;
        checks++;
        if (bus.round_o !== 4'd6) begin
            errors++;
            $display("FAIL reset_round_b: got %0d expected 6", bus.round_o);
        end
        bus.mode_i = 1'b0;
        bus.start_i = 1'b0;
        rst = 1'b0;
        tick();
        #1;
        checks++;
        if ({bus.ready_o, bus.valid_o, bus.ena_reg_state_o, bus.input_select_o, bus.round_o} !== 8'b1001_0000
            || bus.perm_count_o !== 16'd0 || bus_sat.perm_count_o !== 2'd0) begin
            errors++;
            $display("FAIL idle_after_reset: got flags=%b round=%0d cnt=%0d satcnt=%0d expected 1001 0 0 0",
                     {bus.ready_o, bus.valid_o, bus.ena_reg_state_o, bus.input_select_o},
                     bus.round_o, bus.perm_count_o, bus_sat.perm_count_o);
        end
        $display("reset: done");
    endtask

    task automatic test_pa();
        logic [7:0] exp_v;
        logic [7:0] got_v;
        ext_in = 64'h80400c0600000000;
        bus.mode_i = 1'b0;
        bus.ready_i = 1'b1;
        bus.start_i = 1'b1;
        for (int i = 0; i < 12; i++) begin
            #1;
            exp_v = {4'(i), (i == 0), 1'b1, 1'b0, (i == 0)};
            got_v = {bus.round_o, bus.input_select_o, bus.ena_reg_state_o, bus.valid_o, bus.ready_o};
            checks++;
            if (got_v !== exp_v) begin
                errors++;
                $display("FAIL pa_cycle%0d: got round/sel/ena/val/rdy=%b expected %b", i, got_v, exp_v);
            end
            tick();
            bus.start_i = 1'b0;
        end
        #1;
        checks++;
        if ({bus.valid_o, bus.ena_reg_state_o, bus.ready_o, bus.round_o} !== 7'b100_1011) begin
            errors++;
            $display("FAIL pa_done: got val/ena/rdy/round=%b expected 1001011",
                     {bus.valid_o, bus.ena_reg_state_o, bus.ready_o, bus.round_o});
        end
        tick();
        #1;
        checks++;
        if (bus.valid_o !== 1'b0 || bus.ready_o !== 1'b1 || bus.perm_count_o !== 16'd1) begin
            errors++;
            $display("FAIL pa_handoff: got val=%b rdy=%b cnt=%0d expected 0 1 1",
                     bus.valid_o, bus.ready_o, bus.perm_count_o);
        end
        $display("pa: 12-round permutation handed off, count=%0d", bus.perm_count_o);
    endtask

    task automatic test_pb();
        ext_in = 64'h0123456789abcdef;
        bus.mode_i = 1'b1;
        bus.ready_i = 1'b1;
        bus.start_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            checks++;
            if (bus.round_o !== 4'(6 + i) || bus.input_select_o !== (i == 0) || bus.valid_o !== 1'b0) begin
                errors++;
                $display("FAIL pb_cycle%0d: got round=%0d sel=%b val=%b expected %0d %b 0",
                         i, bus.round_o, bus.input_select_o, bus.valid_o, 6 + i, (i == 0));
            end
            tick();
            bus.start_i = 1'b0;
            bus.mode_i = ~bus.mode_i;
        end
        #1;
        checks++;
        if (bus.valid_o !== 1'b1 || bus.round_o !== 4'd11) begin
            errors++;
            $display("FAIL pb_done: got val=%b round=%0d expected 1 11", bus.valid_o, bus.round_o);
        end
        tick();
        #1;
        checks++;
        if (bus.ready_o !== 1'b1 || bus.perm_count_o !== 16'd2) begin
            errors++;
            $display("FAIL pb_handoff: got rdy=%b cnt=%0d expected 1 2", bus.ready_o, bus.perm_count_o);
        end
        $display("pb: 6-round permutation handed off, count=%0d", bus.perm_count_o);
    endtask

    task automatic test_backpressure();
        logic [63:0] snap;
        ext_in = 64'hfedcba9876543210;
        bus.mode_i = 1'b1;
        bus.ready_i = 1'b0;
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
        end
        #1;
        snap = perm_q;
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++;
            if (bus.valid_o !== 1'b1 || bus.ena_reg_state_o !== 1'b0 || perm_q !== snap) begin
                errors++;
                $display("FAIL bp_hold%0d: got val=%b ena=%b state=%h expected 1 0 %h",
                         k, bus.valid_o, bus.ena_reg_state_o, perm_q, snap);
            end
            tick();
        end
        bus.ready_i = 1'b1;
        #1;
        checks++;
        if (bus.valid_o !== 1'b1 || bus.ready_o !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: got val=%b rdy=%b expected 1 0", bus.valid_o, bus.ready_o);
        end
        tick();
        #1;
        checks++;
        if (bus.ready_o !== 1'b1 || bus.valid_o !== 1'b0 || bus.perm_count_o !== 16'd3) begin
            errors++;
            $display("FAIL bp_after: got rdy=%b val=%b cnt=%0d expected 1 0 3",
                     bus.ready_o, bus.valid_o, bus.perm_count_o);
        end
        $display("backpressure: held 5 cycles, count=%0d", bus.perm_count_o);
    endtask

    task automatic test_back_to_back();
        logic exp_acc;
        bus.mode_i = 1'b0;
        bus.ready_i = 1'b1;
        bus.start_i = 1'b1;
        for (int c = 0; c < 39; c++) begin
            #1;
            exp_acc = ((c % 13) == 0);
            checks++;
            if ((bus.ready_o & bus.start_i) !== exp_acc) begin
                errors++;
                $display("FAIL b2b_a_accept_c%0d: got %b expected %b", c, bus.ready_o & bus.start_i, exp_acc);
            end
            if (exp_acc) begin
                checks++;
                if (bus.perm_count_o !== 16'(3 + c / 13)) begin
                    errors++;
                    $display("FAIL b2b_a_count_c%0d: got %0d expected %0d", c, bus.perm_count_o, 3 + c / 13);
                end
            end
            tick();
        end
        bus.mode_i = 1'b1;
        for (int c = 0; c < 28; c++) begin
            #1;
            exp_acc = ((c % 7) == 0);
            checks++;
            if ((bus.ready_o & bus.start_i) !== exp_acc) begin
                errors++;
                $display("FAIL b2b_b_accept_c%0d: got %b expected %b", c, bus.ready_o & bus.start_i, exp_acc);
            end
            if (exp_acc) begin
                checks++;
                if (bus.perm_count_o !== 16'(6 + c / 7)) begin
                    errors++;
                    $display("FAIL b2b_b_count_c%0d: got %0d expected %0d", c, bus.perm_count_o, 6 + c / 7);
                end
            end
            tick();
        end
        bus.start_i = 1'b0;
        #1;
        checks++;
        if (bus.perm_count_o !== 16'd10 || bus.ready_o !== 1'b1) begin
            errors++;
            $display("FAIL b2b_final: got cnt=%0d rdy=%b expected 10 1", bus.perm_count_o, bus.ready_o);
        end
        $display("back_to_back: 7 permutations streamed, count=%0d", bus.perm_count_o);
    endtask

    task automatic test_saturation();
        logic [1:0] exp_sat;
        rst_sat = 1'b1;
        tick();
        rst_sat = 1'b0;
        for (int c = 0; c < 36; c++) begin
            #1;
            if (c > 0 && (c % 7) == 0) begin
                exp_sat = (c / 7 > 3) ? 2'd3 : 2'(c / 7);
                checks++;
                if (bus_sat.perm_count_o !== exp_sat) begin
                    errors++;
                    $display("FAIL sat_count_c%0d: got %0d expected %0d", c, bus_sat.perm_count_o, exp_sat);
                end
            end
            tick();
        end
        $display("saturation: narrow counter reads %0d", bus_sat.perm_count_o);
    endtask

    task automatic test_midrun_reset();
        logic seen_valid;
        ext_in = 64'h80400c0600000000;
        bus.mode_i = 1'b0;
        bus.ready_i = 1'b1;
        bus.start_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            bus.start_i = 1'b0;
        end
        #1;
        checks++;
        if (bus.round_o !== 4'd5 || bus.ena_reg_state_o !== 1'b1) begin
            errors++;
            $display("FAIL mid_round5: got round=%0d ena=%b expected 5 1", bus.round_o, bus.ena_reg_state_o);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.ready_o, bus.valid_o, bus.ena_reg_state_o, bus.input_select_o, bus.round_o} !== 8'b1001_0000) begin
            errors++;
            $display("FAIL mid_in_reset: got rdy/val/ena/sel/round=%b expected 10010000",
                     {bus.ready_o, bus.valid_o, bus.ena_reg_state_o, bus.input_select_o, bus.round_o});
        end
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (bus.ready_o !== 1'b1 || bus.valid_o !== 1'b0 || bus.perm_count_o !== 16'd0) begin
            errors++;
            $display("FAIL mid_after_reset: got rdy=%b val=%b cnt=%0d expected 1 0 0",
                     bus.ready_o, bus.valid_o, bus.perm_count_o);
        end
        seen_valid = 1'b0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (bus.valid_o === 1'b1) seen_valid = 1'b1;
        end
        checks++;
        if (seen_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_no_valid: got valid pulse=%b expected 0", seen_valid);
        end
        bus.mode_i = 1'b1;
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
        end
        #1;
        checks++;
        if (bus.valid_o !== 1'b1) begin
            errors++;
            $display("FAIL mid_rerun_valid: got %b expected 1", bus.valid_o);
        end
        tick();
        #1;
        checks++;
        if (bus.perm_count_o !== 16'd1 || bus.ready_o !== 1'b1) begin
            errors++;
            $display("FAIL mid_rerun_count: got cnt=%0d rdy=%b expected 1 1", bus.perm_count_o, bus.ready_o);
        end
        $display("midrun_reset: aborted run dropped, rerun count=%0d", bus.perm_count_o);
    endtask

    initial begin
        test_reset();
        test_pa();
        test_pb();
        test_backpressure();
        test_back_to_back();
        test_saturation();
        test_midrun_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
